// File: rtl/matmul_sequencer.sv
// Command-driven sequencer for the ternary matmul datapath: loads packed weights,
// streams activations into the MAC slices and drains one result per active slice.
module matmul_sequencer #(
    parameter int SLICES  = 4,
    parameter int WADDR_W = 4,
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 2,
    localparam int SEL_W  = (SLICES > 1) ? $clog2(SLICES) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         cfg_slices,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic               data_valid,
    output logic               data_ready,
    output logic               w_we,
    output logic [SEL_W-1:0]   w_slice,
    output logic [WADDR_W-1:0] w_addr,
    output logic               mac_clear,
    output logic               mac_en,
    output logic               mac_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   out_sel,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int FL_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [FL_W-1:0]    FLUSH_LAST = FL_W'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);
    localparam logic [SEL_W-1:0]   SLICE_MAX  = SEL_W'(SLICES - 1);
    localparam logic [WADDR_W-1:0] ADDR_MAX   = '1;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_RUN   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_RUN_CLR,
        S_RUN_STREAM,
        S_RUN_FLUSH,
        S_DRAIN
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [LEN_W-1:0]    beat_cnt;
    logic [FL_W-1:0]     flush_cnt;
    logic [SEL_W-1:0]    last_sel;
    logic                in_range;
    logic                clear_pulse;
    logic                cmd_fire;
    logic                bad_cfg;

    assign cmd_fire = cmd_valid & cmd_ready;
    assign bad_cfg  = (cfg_slices == 8'd0) || (int'(cfg_slices) > SLICES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = (state == S_IDLE);
        data_ready = (state == S_LOAD_W) || (state == S_RUN_STREAM);
        out_valid  = (state == S_DRAIN);
        busy       = (state != S_IDLE);
        w_we       = (state == S_LOAD_W) && data_valid && in_range;
        mac_en     = (state == S_RUN_STREAM) && data_valid;
        mac_last   = mac_en && (beat_cnt == LEN_W'(1));
        mac_clear  = (state == S_RUN_CLR) || clear_pulse;

        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_len != '0) begin
                    if (cmd_op == OP_LOAD) begin
                        state_next = S_LOAD_W;
                    end else if (cmd_op == OP_RUN) begin
                        state_next = S_RUN_CLR;
                    end
                end
            end
            S_LOAD_W: begin
                if (data_valid && beat_cnt == LEN_W'(1)) begin
                    state_next = S_IDLE;
                end
            end
            S_RUN_CLR: begin
                state_next = S_RUN_STREAM;
            end
            S_RUN_STREAM: begin
                if (mac_last) begin
                    state_next = S_RUN_FLUSH;
                end
            end
            S_RUN_FLUSH: begin
                if (flush_cnt == FLUSH_LAST) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_ready && out_sel == last_sel) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Once the write pointer runs off the last slice it freezes; later beats are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt    <= '0;
            flush_cnt   <= '0;
            last_sel    <= '0;
            in_range    <= 1'b0;
            clear_pulse <= 1'b0;
            w_slice     <= '0;
            w_addr      <= '0;
            out_sel     <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done        <= busy && (state_next == S_IDLE);
            clear_pulse <= cmd_fire && (cmd_op == OP_CLEAR);

            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        case (cmd_op)
                            OP_CLEAR: begin
                                err <= 1'b0;
                            end
                            OP_LOAD: begin
                                if (cmd_len == '0) begin
                                    err <= 1'b1;
                                end else begin
                                    beat_cnt <= cmd_len;
                                    w_slice  <= '0;
                                    w_addr   <= '0;
                                    in_range <= 1'b1;
                                end
                            end
                            OP_RUN: begin
                                if (cmd_len == '0) begin
                                    err <= 1'b1;
                                end else begin
                                    beat_cnt  <= cmd_len;
                                    flush_cnt <= '0;
                                    out_sel   <= '0;
                                    if (bad_cfg) begin
                                        err      <= 1'b1;
                                        last_sel <= SLICE_MAX;
                                    end else begin
                                        last_sel <= SEL_W'(cfg_slices - 8'd1);
                                    end
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                S_LOAD_W: begin
                    if (data_valid) begin
                        beat_cnt <= beat_cnt - LEN_W'(1);
                        if (in_range) begin
                            if (w_addr == ADDR_MAX) begin
                                if (w_slice == SLICE_MAX) begin
                                    in_range <= 1'b0;
                                    err      <= 1'b1;
                                end else begin
                                    w_addr  <= '0;
                                    w_slice <= w_slice + SEL_W'(1);
                                end
                            end else begin
                                w_addr <= w_addr + WADDR_W'(1);
                            end
                        end
                    end
                end
                S_RUN_STREAM: begin
                    if (data_valid) begin
                        beat_cnt <= beat_cnt - LEN_W'(1);
                    end
                end
                S_RUN_FLUSH: begin
                    flush_cnt <= flush_cnt + FL_W'(1);
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (out_sel == last_sel) begin
                            out_sel <= '0;
                        end else begin
                            out_sel <= out_sel + SEL_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
